// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the seven-segment display driver.
//   SEG_0 .. SEG_F : active-high glyphs, bit 0 = segment a ... bit 6 = segment g
//   SEG_DASH       : segment g only, shown in every digit on overflow
//   SEG_OFF        : all segments dark
//   state_t        : controller states (IDLE, SHIFT, UPDATE)
package display_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_A    = 7'h77;
   localparam logic [6:0] SEG_B    = 7'h7C;
   localparam logic [6:0] SEG_C    = 7'h39;
   localparam logic [6:0] SEG_D    = 7'h5E;
   localparam logic [6:0] SEG_E    = 7'h79;
   localparam logic [6:0] SEG_F    = 7'h71;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_display_driver_if.sv
// bcd_display_driver_if
// Request/result bundle between the ALU result register and the display driver.
//   start, value, hex_mode, blank_lz : update request (driven by master)
//   busy, done, overflow, hex_out    : driver status and segment patterns (driven by slave)
// Modports: master = requester side, slave = display driver side.
interface bcd_display_driver_if #(
   parameter int WIDTH      = 16,
   parameter int NUM_DIGITS = 4
);

   logic                    start;
   logic [WIDTH-1:0]        value;
   logic                    hex_mode;
   logic                    blank_lz;
   logic                    busy;
   logic                    done;
   logic                    overflow;
   logic [7*NUM_DIGITS-1:0] hex_out;

   modport master (
      output start, value, hex_mode, blank_lz,
      input  busy, done, overflow, hex_out
   );

   modport slave (
      input  start, value, hex_mode, blank_lz,
      output busy, done, overflow, hex_out
   );

endinterface

// File: rtl/bcd_display_driver_seg7_encode.sv
// seg7_encode
// Combinational digit to seven-segment glyph lookup.
//   digit  : 4-bit digit value
//   hex_en : 1 = show 10..15 as A b C d E F, 0 = leave them dark
//   seg    : active-high segment pattern, bit 0 = segment a
module seg7_encode
   import display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       hex_en,
   output logic [6:0] seg
);

   // Plain lookup; letters only light up when the caller is in hex mode,
   // since a decimal digit above 9 would indicate a conversion fault.
   always_comb begin
      seg = SEG_OFF;
      case (digit)
         4'd0:  seg = SEG_0;
         4'd1:  seg = SEG_1;
         4'd2:  seg = SEG_2;
         4'd3:  seg = SEG_3;
         4'd4:  seg = SEG_4;
         4'd5:  seg = SEG_5;
         4'd6:  seg = SEG_6;
         4'd7:  seg = SEG_7;
         4'd8:  seg = SEG_8;
         4'd9:  seg = SEG_9;
         4'd10: seg = hex_en ? SEG_A : SEG_OFF;
         4'd11: seg = hex_en ? SEG_B : SEG_OFF;
         4'd12: seg = hex_en ? SEG_C : SEG_OFF;
         4'd13: seg = hex_en ? SEG_D : SEG_OFF;
         4'd14: seg = hex_en ? SEG_E : SEG_OFF;
         4'd15: seg = hex_en ? SEG_F : SEG_OFF;
      endcase
   end

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver
// Converts an unsigned result to NUM_DIGITS registered seven-segment patterns.
// Decimal mode runs a double-dabble conversion one bit per clock; hex mode
// splits the value into nibbles and updates after a single cycle.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of bcd_display_driver_if
//           start/value/hex_mode/blank_lz in, busy/done/overflow/hex_out out
module bcd_display_driver
   import display_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int NUM_DIGITS = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   bcd_display_driver_if.slave    bus
);

   localparam int BCD_DIGITS = (WIDTH + 2) / 3;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam int HEX_W      = 7 * NUM_DIGITS;
   localparam int EXT_W      = 4 * NUM_DIGITS + BCD_W + WIDTH;
   localparam logic [6:0] OFF_PAT = ACTIVE_LOW ? 7'h7F : 7'h00;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               hex_mode_q, hex_mode_d;
   logic               blank_lz_q, blank_lz_d;
   logic [HEX_W-1:0]   hex_out_q, hex_out_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]   bcd_adj;
   logic [EXT_W-1:0]   digits_ext;
   logic               ovf;
   logic [3:0]         digit [NUM_DIGITS];
   logic [6:0]         enc   [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] blank;
   logic [HEX_W-1:0]   disp;

   // Double-dabble correction: any BCD digit of 5 or more gets 3 added so
   // that the following left shift carries correctly into the next digit.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                       : bcd_q[4*i +: 4];
      end
   end

   // Zero-extend the digit source far enough that every display digit and
   // every digit beyond the display can be addressed uniformly. In hex mode
   // the latched value still sits untouched in the shift register.
   always_comb begin
      digits_ext = hex_mode_q ? EXT_W'(shift_q) : EXT_W'(bcd_q);
      ovf        = |(digits_ext >> (4 * NUM_DIGITS));
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      assign digit[g] = digits_ext[4*g +: 4];
      seg7_encode u_seg7_encode (
         .digit  (digit[g]),
         .hex_en (hex_mode_q),
         .seg    (enc[g])
      );
   end

   // Leading-zero blanking walks down from the top digit and stops at the
   // first nonzero one. Digit 0 is never blanked so zero still shows "0".
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank    = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run & (digit[i] == 4'd0);
         blank[i] = blank_lz_q & zero_run;
      end
   end

   // Final pattern per digit: overflow dashes take priority over blanking,
   // and polarity is applied last so the glyph tables stay active-high.
   always_comb begin
      logic [6:0] pat;
      disp = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         pat = ovf ? SEG_DASH : (blank[i] ? SEG_OFF : enc[i]);
         disp[7*i +: 7] = ACTIVE_LOW ? ~pat : pat;
      end
   end

   // Controller next-state logic. Requests are only looked at in IDLE, so a
   // start during a conversion is simply dropped. The display registers are
   // written only in UPDATE, giving whole-display updates.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      bcd_d      = bcd_q;
      hex_mode_d = hex_mode_q;
      blank_lz_d = blank_lz_q;
      hex_out_d  = hex_out_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d    = bus.value;
               hex_mode_d = bus.hex_mode;
               blank_lz_d = bus.blank_lz;
               bcd_d      = '0;
               cnt_d      = CNT_W'(WIDTH);
               state_d    = bus.hex_mode ? UPDATE : SHIFT;
            end
         end
         SHIFT: begin
            bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_d == '0) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            hex_out_d  = disp;
            overflow_d = ovf;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset discards any pending conversion and
   // darkens the display immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         bcd_q      <= '0;
         hex_mode_q <= 1'b0;
         blank_lz_q <= 1'b0;
         hex_out_q  <= {NUM_DIGITS{OFF_PAT}};
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bcd_q      <= bcd_d;
         hex_mode_q <= hex_mode_d;
         blank_lz_q <= blank_lz_d;
         hex_out_q  <= hex_out_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = done_q;
   assign bus.overflow = overflow_q;
   assign bus.hex_out  = hex_out_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver
// Directed bench for bcd_display_driver with WIDTH = 16, NUM_DIGITS = 4,
// ACTIVE_LOW = 1. A vector table covers decimal, hex, blanking and overflow;
// hand-written sequences cover back-to-back starts, starts while busy and
// reset in the middle of a conversion.
module tb_bcd_display_driver;

   localparam int WIDTH      = 16;
   localparam int NUM_DIGITS = 4;
   localparam int MAX_WAIT   = 100;

   typedef struct {
      string       name;
      logic [15:0] value;
      logic        hex_mode;
      logic        blank_lz;
      logic [27:0] exp_hex;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   fails;

   bcd_display_driver_if #(.WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS)) bus ();

   bcd_display_driver #(
      .WIDTH      (WIDTH),
      .NUM_DIGITS (NUM_DIGITS),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so a stuck design cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
      return {d3, d2, d1, d0};
   endfunction

   // One comparison: bumps the counters and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Issue one start request and wait (bounded) for done. lat counts the
   // rising edges after the accepting edge up to the one that raised done.
   task automatic applyStimulus(input logic [15:0] value, input logic hex_mode,
                                input logic blank_lz, output int lat);
      @(negedge clk);
      bus.value    = value;
      bus.hex_mode = hex_mode;
      bus.blank_lz = blank_lz;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < MAX_WAIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t vecs[12];
   int   lat;
   int   done_cnt;
   logic [27:0] seen_hex;

   initial begin
      checks       = 0;
      fails        = 0;
      bus.start    = 1'b0;
      bus.value    = '0;
      bus.hex_mode = 1'b0;
      bus.blank_lz = 1'b0;

      vecs[0]  = '{"dec_1234",   16'd1234,  1'b0, 1'b0, pack4(7'h79, 7'h24, 7'h30, 7'h19), 1'b0, 17};
      vecs[1]  = '{"dec_42_lz",  16'd42,    1'b0, 1'b1, pack4(7'h7F, 7'h7F, 7'h19, 7'h24), 1'b0, 17};
      vecs[2]  = '{"dec_0_lz",   16'd0,     1'b0, 1'b1, pack4(7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0, 17};
      vecs[3]  = '{"dec_12345",  16'd12345, 1'b0, 1'b0, pack4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1, 17};
      vecs[4]  = '{"dec_5678",   16'd5678,  1'b0, 1'b0, pack4(7'h12, 7'h02, 7'h78, 7'h00), 1'b0, 17};
      vecs[5]  = '{"dec_65535",  16'd65535, 1'b0, 1'b1, pack4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1, 17};
      vecs[6]  = '{"dec_9999",   16'd9999,  1'b0, 1'b0, pack4(7'h10, 7'h10, 7'h10, 7'h10), 1'b0, 17};
      vecs[7]  = '{"dec_1000_lz",16'd1000,  1'b0, 1'b1, pack4(7'h79, 7'h40, 7'h40, 7'h40), 1'b0, 17};
      vecs[8]  = '{"dec_10000",  16'd10000, 1'b0, 1'b0, pack4(7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1, 17};
      vecs[9]  = '{"hex_BEEF",   16'hBEEF,  1'b1, 1'b0, pack4(7'h03, 7'h06, 7'h06, 7'h0E), 1'b0, 1};
      vecs[10] = '{"hex_00A0_lz",16'h00A0,  1'b1, 1'b1, pack4(7'h7F, 7'h7F, 7'h08, 7'h40), 1'b0, 1};
      vecs[11] = '{"hex_00C5",   16'h00C5,  1'b1, 1'b0, pack4(7'h40, 7'h40, 7'h46, 7'h12), 1'b0, 1};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] reset released");
      checkOutput("reset_hex_out",  32'(bus.hex_out),  32'h0FFF_FFFF);
      checkOutput("reset_busy",     32'(bus.busy),     32'd0);
      checkOutput("reset_done",     32'(bus.done),     32'd0);
      checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);

      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].value, vecs[v].hex_mode, vecs[v].blank_lz, lat);
         checkOutput({vecs[v].name, "_latency"},  32'(lat),          32'(vecs[v].exp_lat));
         checkOutput({vecs[v].name, "_hex_out"},  32'(bus.hex_out),  32'(vecs[v].exp_hex));
         checkOutput({vecs[v].name, "_overflow"}, 32'(bus.overflow), 32'(vecs[v].exp_ovf));
         checkOutput({vecs[v].name, "_busy"},     32'(bus.busy),     32'd0);
         @(negedge clk);
         checkOutput({vecs[v].name, "_done_width"}, 32'(bus.done), 32'd0);
      end

      $display("[TB] back-to-back hex updates");
      applyStimulus(16'hBEEF, 1'b1, 1'b0, lat);
      checkOutput("b2b_first_hex_out", 32'(bus.hex_out), 32'(pack4(7'h03, 7'h06, 7'h06, 7'h0E)));
      bus.value    = 16'h1234;
      bus.hex_mode = 1'b1;
      bus.blank_lz = 1'b0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      checkOutput("b2b_second_done",    32'(bus.done),    32'd1);
      checkOutput("b2b_second_hex_out", 32'(bus.hex_out), 32'(pack4(7'h79, 7'h24, 7'h30, 7'h19)));

      $display("[TB] starts while busy");
      @(negedge clk);
      bus.value    = 16'd1234;
      bus.hex_mode = 1'b0;
      bus.blank_lz = 1'b0;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      done_cnt  = 0;
      seen_hex  = '0;
      lat       = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.done) begin
            done_cnt++;
            seen_hex = bus.hex_out;
            lat      = n;
         end
         if (n < 13 && (n % 3) == 0) begin
            bus.value    = 16'd9999;
            bus.hex_mode = 1'b1;
            bus.start    = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      checkOutput("busy_start_done_count", 32'(done_cnt), 32'd1);
      checkOutput("busy_start_latency",    32'(lat),      32'd17);
      checkOutput("busy_start_hex_out",    32'(seen_hex), 32'(pack4(7'h79, 7'h24, 7'h30, 7'h19)));

      $display("[TB] reset during conversion");
      @(negedge clk);
      bus.value    = 16'd42;
      bus.hex_mode = 1'b0;
      bus.blank_lz = 1'b1;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("mid_reset_hex_out",  32'(bus.hex_out),  32'h0FFF_FFFF);
      checkOutput("mid_reset_busy",     32'(bus.busy),     32'd0);
      checkOutput("mid_reset_done",     32'(bus.done),     32'd0);
      checkOutput("mid_reset_overflow", 32'(bus.overflow), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      checkOutput("post_reset_done_count", 32'(done_cnt),     32'd0);
      checkOutput("post_reset_hex_out",    32'(bus.hex_out),  32'h0FFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Multi-digit seven-segment display driver for the calculator datapath. It accepts a WIDTH-bit unsigned result through a start handshake. In decimal mode it converts the value to BCD with an iterative shift-add-3 (double-dabble) sequence, one bit per clock; in hex mode it splits the value into nibbles. It then drives NUM_DIGITS registered segment patterns, with optional leading-zero blanking and overflow indication. It sits between the ALU result register and the board's HEX displays.

## Interface
- WIDTH, 16: bit width of the input value (≥4).
- NUM_DIGITS, 4: number of displayed digits (1..8).
- ACTIVE_LOW, 1: 1 = segment outputs inverted (lit = 0), 0 = lit = 1.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a display update; sampled only when busy = 0.
- value  input  WIDTH  unsigned value; sampled on the accepted start edge.
- hex_mode  input  1  0 = decimal, 1 = hexadecimal; sampled with value.
- blank_lz  input  1  1 = blank leading zeros; sampled with value.
- busy  output  1  high while the conversion is in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse, coincident with new hex_out.
- overflow  output  1  value did not fit in NUM_DIGITS; held until next update.
- hex_out  output  7*NUM_DIGITS  segment patterns; digit i at [7i+6:7i], digit 0 = least significant; bit 0 = seg a … bit 6 = seg g.

## Operation
- Reset values: hex_out = all segments off (all ones when ACTIVE_LOW = 1), busy = 0, done = 0, overflow = 0, state = IDLE.
- The FSM has three states: IDLE, SHIFT, UPDATE.
- IDLE: on start = 1, latch value, hex_mode and blank_lz.
  - Decimal mode: clear the BCD register, load the shift register, go to SHIFT with bit counter = WIDTH.
  - Hex mode: go to UPDATE directly.
- SHIFT: add 3 to each BCD digit ≥ 5, then shift left by one bit, bringing in the value's MSB.
  - Decrement the counter; go to UPDATE when it reaches 0 (exactly WIDTH SHIFT cycles).
- Internal BCD width: BCD_DIGITS = (WIDTH+2)/3 digits (localparam). This always holds the full result.
- UPDATE: form the digit vector, then register hex_out and overflow, pulse done, and return to IDLE.
  - Decimal: digits are the BCD digits. Overflow if any digit at index ≥ NUM_DIGITS is nonzero.
  - Hex: digits are the nibbles. Overflow if any value bit at index ≥ 4*NUM_DIGITS is 1.
  - On overflow, every digit shows a dash (seg g only, 0x40 active-high). blank_lz is ignored.
  - Otherwise, encode digits 0–9 with the standard patterns: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F.
  - In hex mode, encode digits 10–15 as A 0x77, b 0x7C, C 0x39, d 0x5E, E 0x79, F 0x71.
  - With blank_lz = 1, every digit above the most significant nonzero digit is off (0x00). Digit 0 is never blanked, so value 0 displays "0".
  - When ACTIVE_LOW = 1, invert the final pattern.
- A start while busy = 1 is ignored: not queued, and no effect on the conversion in progress.
- hex_out holds its previous contents during SHIFT and UPDATE. There are no partial updates.
- Reset mid-conversion: return immediately to the reset values. The display blanks and the pending update is discarded.

## Timing
- Accepted start at edge E0: busy = 1 from E0.
- Decimal mode: SHIFT runs on edges E1..E_WIDTH; UPDATE registers the outputs at E_WIDTH+1.
  - New hex_out, overflow and done = 1 appear together after E_WIDTH+1. busy = 0 in that same cycle.
  - Latency is WIDTH+1 cycles (17 cycles for WIDTH = 16).
- Hex mode: UPDATE registers the outputs at E1 (latency 1).
- done is high for exactly one cycle.
- A start asserted during the done cycle is accepted, giving back-to-back updates with no idle gap.
- All outputs are registered. Nothing is combinational from the inputs to the outputs.

## Structure
- Shared package display_pkg holds:
  - the seven-segment constants SEG_0..SEG_F, SEG_DASH and SEG_OFF (active-high, bit 0 = a);
  - the state enum (IDLE, SHIFT, UPDATE).
- Sub-module seg7_encode: combinational, inputs 4-bit digit plus hex_en, output 7-bit active-high pattern. Returns SEG_OFF for 10–15 when hex_en = 0.
- Instantiate seg7_encode NUM_DIGITS times in a generate loop.
- Blanking, the dash override and the ACTIVE_LOW inversion are applied in the parent.

## Test plan
(All cases use WIDTH = 16, NUM_DIGITS = 4, ACTIVE_LOW = 1; hex_out is written digit 3 … digit 0.)
- Reset asserted, then released → hex_out = 0x7F in every digit, busy = 0, done = 0, overflow = 0.
- Decimal 1234, blank_lz = 0 → 0x79, 0x24, 0x30, 0x19; done 17 cycles after the start edge; overflow = 0.
- Decimal 42, blank_lz = 1 → 0x7F, 0x7F, 0x19, 0x24. Decimal 0, blank_lz = 1 → 0x7F, 0x7F, 0x7F, 0x40.
- Decimal 12345 → overflow = 1, all digits 0x3F (dash). Decimal 65535 → same.
- Hex mode 0xBEEF → 0x03, 0x06, 0x06, 0x0E; done 1 cycle after start. A start during the done cycle is accepted.
- Start pulses during SHIFT are ignored (only one done). reset at the 5th SHIFT cycle → immediate blank display, busy = 0, no done.
